mem_rmw_port: RTL and testbench
===============================

# mem_rmw_port

Request/response front end for the single-port synchronous RAM (one `cs`, one `wen`, shared address, registered read data, one-cycle read latency). Upstream masters (CPU data port, debug loader) issue word reads and byte-masked writes over a valid/ready handshake. The block sequences the RAM strobes, absorbs its read latency, and performs read-modify-write for partial writes. It sits directly upstream of the RAM and drives all of its inputs.

## Interface
- `WIDTH`, 32, data word width in bits; must be a multiple of 8.
- `ADDR_SIZE`, 10, word address width; must match the RAM's `ADDR_SIZE`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low: low at a rising edge resets the block.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts a request; handshake completes when both `req_valid` and `req_ready` are high at a rising edge.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_SIZE  word address.
- `req_wdata`  in  WIDTH  write data.
- `req_be`  in  WIDTH/8  byte enables; bit i covers bits [8i+7:8i]. Ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse: read data valid or write done. No backpressure.
- `rsp_rdata`  out  WIDTH  read data; updated only on reads.
- `mem_cs`  out  1  RAM chip select.
- `mem_wen`  out  1  RAM write enable.
- `mem_ra`  out  ADDR_SIZE  RAM address.
- `mem_din`  out  WIDTH  RAM write data.
- `mem_dout`  in  WIDTH  RAM registered read data.

## Operation
- All outputs except `req_ready` are registered. `req_ready` = (state == IDLE) & reset high.
- States: IDLE, RD, RDW, MRG, WR.
- IDLE:
  - On handshake, latch the address, data and byte enables.
  - Read: go to RD.
  - Write with all `req_be` bits set: go to WR.
  - Write with `req_be` == 0: go to WR with `mem_cs`=0. No RAM access; acknowledge only.
  - Any other write: go to RD, flagged as RMW.
- RD: `mem_cs`=1, `mem_wen`=0, `mem_ra`=latched address. Next state is RDW for a read, MRG for an RMW.
- RDW: `mem_cs`=0; `mem_dout` is valid. At the edge, `rsp_rdata`<=`mem_dout`, `rsp_valid`<=1, go to IDLE.
- MRG: `mem_cs`=0. At the edge, compute merged byte i = `req_be`[i] ? latched wdata byte i : `mem_dout` byte i. Load `mem_din`<=merged and go to WR.
- WR: `mem_cs`=1 (0 for the be==0 case), `mem_wen`=1, `mem_ra`=latched address, `mem_din`=data. At the edge, `rsp_valid`<=1, go to IDLE.
- `rsp_valid` is high for exactly one cycle per accepted request. Responses return in request order; only one request is outstanding at a time.
- `mem_wen` is 0 whenever `mem_cs` is 0.
- `mem_ra` and `mem_din` hold their last values when idle.

## Timing
- Latency, counted in rising edges from the handshake edge H to the edge that raises `rsp_valid`:
  - read: H+2;
  - full write: H+1;
  - be==0 write: H+1;
  - partial write (RMW): H+3.
- `req_ready` is high in the cycle `rsp_valid` is high, so a new request can be accepted at that edge. Back-to-back full writes sustain one request every 2 cycles; reads one every 3.
- Reset values, held while `reset` is low:
  - state = IDLE;
  - `req_ready`, `rsp_valid`, `mem_cs`, `mem_wen` = 0;
  - `mem_ra`, `mem_din`, `rsp_rdata` = 0.
- Reset mid-operation:
  - The transaction is aborted and no response is issued.
  - A WR cycle already driving `mem_cs`&`mem_wen` at the reset edge completes in the RAM, because the strobes were registered before that edge.
  - An RMW aborted in RD or MRG leaves the RAM unmodified.
- `req_*` inputs are sampled only at the handshake edge; changes in later cycles have no effect.

## Test plan
- Reset: hold `reset` low 3 cycles with `req_valid`=1 -> `req_ready`=0, `mem_cs`=0, `rsp_valid`=0, `rsp_rdata`=0; no RAM access.
- Full write then read: write addr 0x005, data 0xDEADBEEF, be=0xF. Expect `rsp_valid` at H+1. Then read 0x005: expect `rsp_valid` at H+2 with `rsp_rdata`=0xDEADBEEF.
- RMW: RAM[0x010]=0x11223344. Write data 0xAABBCCDD, be=0b0101. Expect `rsp_valid` at H+3, one `mem_cs`&`mem_wen` cycle with `mem_din`=0x11BB33DD, and a readback of 0x11BB33DD.
- be==0 write to 0x3FF holding 0x12345678 -> `rsp_valid` at H+1, `mem_cs` never asserted, readback 0x12345678.
- Back-to-back: hold `req_valid` high across 4 full writes -> handshakes every 2 cycles, 4 `rsp_valid` pulses; readbacks return all 4 values in order.
- Reset during RMW: drop `reset` in the MRG cycle -> no `rsp_valid`, no write strobe; the RAM word keeps its old value and `req_ready` returns 1 cycle after `reset` rises.

Source files
------------

// File: rtl/mem_rmw_port.sv
// Request/response front end for a single-port synchronous RAM with one-cycle read latency.
// Sequences the RAM strobes and turns partial (byte-masked) writes into read-modify-write.
module mem_rmw_port #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [WIDTH/8-1:0]   req_be,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 mem_cs,
  output logic                 mem_wen,
  output logic [ADDR_SIZE-1:0] mem_ra,
  output logic [WIDTH-1:0]     mem_din,
  input  logic [WIDTH-1:0]     mem_dout
);

  localparam int unsigned NumBytes = WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StRd, StRdw, StMrg, StWr} state_e;

  state_e                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [NumBytes-1:0]    be_q, be_d;
  logic                   mem_cs_q, mem_cs_d;
  logic                   mem_wen_q, mem_wen_d;
  logic [ADDR_SIZE-1:0]   mem_ra_q, mem_ra_d;
  logic [WIDTH-1:0]       mem_din_q, mem_din_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [WIDTH-1:0]       merged;

  assign req_ready = (state_q == StIdle) && reset;

  // Byte-wise merge of latched write data over the word just read from the RAM.
  always_comb begin
    merged = mem_dout;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state and registered-output logic; strobes are computed for the following cycle.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    mem_cs_d    = 1'b0;
    mem_wen_d   = 1'b0;
    mem_ra_d    = mem_ra_q;
    mem_din_d   = mem_din_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          wr_d     = req_wr;
          wdata_d  = req_wdata;
          be_d     = req_be;
          mem_ra_d = req_addr;
          if (!req_wr) begin
            state_d  = StRd;
            mem_cs_d = 1'b1;
          end else if (&req_be) begin
            state_d   = StWr;
            mem_cs_d  = 1'b1;
            mem_wen_d = 1'b1;
            mem_din_d = req_wdata;
          end else if (req_be == '0) begin
            // Acknowledge-only write: pass through WR without touching the RAM.
            state_d   = StWr;
            mem_din_d = req_wdata;
          end else begin
            state_d  = StRd;
            mem_cs_d = 1'b1;
          end
        end
      end
      StRd: begin
        state_d = wr_q ? StMrg : StRdw;
      end
      StRdw: begin
        rsp_rdata_d = mem_dout;
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      StMrg: begin
        mem_din_d = merged;
        mem_cs_d  = 1'b1;
        mem_wen_d = 1'b1;
        state_d   = StWr;
      end
      StWr: begin
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      mem_cs_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_ra_q    <= '0;
      mem_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      mem_cs_q    <= mem_cs_d;
      mem_wen_q   <= mem_wen_d;
      mem_ra_q    <= mem_ra_d;
      mem_din_q   <= mem_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_wen   = mem_wen_q;
  assign mem_ra    = mem_ra_q;
  assign mem_din   = mem_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_rmw_port.sv
// Self-checking bench for mem_rmw_port with an attached behavioural single-port RAM.
module tb_mem_rmw_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_cs;
  logic        mem_wen;
  logic [9:0]  mem_ra;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  mem_rmw_port #(.WIDTH(32), .ADDR_SIZE(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_cs    (mem_cs),
    .mem_wen   (mem_wen),
    .mem_ra    (mem_ra),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_val(input int i);
    if (i == 16)   return 32'h11223344;
    if (i == 1023) return 32'h12345678;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // Behavioural RAM: registered read, write on cs&wen; preloaded on the first edge.
  logic [31:0] ram [1024];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (mem_cs) begin
      if (mem_wen) ram[mem_ra] <= mem_din;
      else         mem_dout <= ram[mem_ra];
    end
  end

  // Activity counters seen at each rising edge.
  int          cyc = 0;
  int          strobes = 0;
  int          cs_cycles = 0;
  int          rsp_cnt = 0;
  logic [31:0] last_din = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_cs && mem_wen) begin
      strobes  <= strobes + 1;
      last_din <= mem_din;
    end
    if (mem_cs) cs_cycles <= cs_cycles + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  // Reference memory contents.
  logic [31:0] model [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected outcome of one request, updating the reference memory.
  task automatic model_step(input logic wr, input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] be, output int lat, output logic [31:0] rd,
                            output int nstb, output logic [31:0] din);
    logic [31:0] m;
    rd = '0; din = '0; nstb = 0;
    if (!wr) begin
      lat = 2;
      rd  = model[a];
    end else if (be == 4'h0) begin
      lat = 1;
    end else begin
      m = model[a];
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
      lat      = (be == 4'hF) ? 1 : 3;
      nstb     = 1;
      din      = m;
      model[a] = m;
    end
  endtask

  // Issue one request and measure its latency, read data and write strobes.
  task automatic do_req(input logic wr, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat, output logic [31:0] rd,
                        output int nstb, output logic [31:0] din);
    int s0;
    bit hs;
    @(posedge clk); #1;
    s0 = strobes;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_be = be;
    hs = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin hs = 1'b1; break; end
    end
    lat = -1;
    if (hs) begin
      @(posedge clk); #1;
      // Scramble inputs after the handshake; they must not matter any more.
      req_valid = 1'b0; req_addr = 10'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
      req_wr = 1'($urandom);
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); #1;
        if (rsp_valid) begin lat = k; break; end
      end
    end else begin
      req_valid = 1'b0;
    end
    rd   = rsp_rdata;
    nstb = strobes - s0;
    din  = last_din;
    if (lat > 0) begin
      @(posedge clk); #1;
      chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
    int          nstb;
    logic [31:0] din;
  } vec_t;

  vec_t        tbl [9];
  int          lat, nstb, elat, enstb, r0, s0;
  logic [31:0] rd, din, erd, edin, old;
  logic        wr;
  logic [9:0]  a;
  logic [31:0] d;
  logic [3:0]  be;
  int          hs_cyc [4];
  logic [31:0] b2b_data [4];
  int          idx, guard;

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = init_val(i);

    tbl[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1, 32'h0,        1, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 10'h005, 32'h0,        4'h0, 2, 32'hDEADBEEF, 0, 32'h0};
    tbl[2] = '{1'b1, 10'h010, 32'hAABBCCDD, 4'h5, 3, 32'h0,        1, 32'h11BB33DD};
    tbl[3] = '{1'b0, 10'h010, 32'h0,        4'h0, 2, 32'h11BB33DD, 0, 32'h0};
    tbl[4] = '{1'b1, 10'h3FF, 32'h0,        4'h0, 1, 32'h0,        0, 32'h0};
    tbl[5] = '{1'b0, 10'h3FF, 32'h0,        4'h0, 2, 32'h12345678, 0, 32'h0};
    tbl[6] = '{1'b1, 10'h011, 32'hFFFFFFFF, 4'hF, 1, 32'h0,        1, 32'hFFFFFFFF};
    tbl[7] = '{1'b1, 10'h011, 32'h00000000, 4'hA, 3, 32'h0,        1, 32'h00FF00FF};
    tbl[8] = '{1'b0, 10'h011, 32'h0,        4'h0, 2, 32'h00FF00FF, 0, 32'h0};

    // Reset held with a pending request: nothing may happen.
    reset = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h005; req_be = 4'hF;
    req_wdata = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_mem_cs", 32'(mem_cs), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    end
    chk("reset_no_ram_access", 32'(cs_cycles), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, lat, rd, nstb, din);
      model_step(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, elat, erd, enstb, edin);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d_write_strobes", i), 32'(nstb), 32'(tbl[i].nstb));
      if (!tbl[i].wr) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
      if (tbl[i].nstb == 1) chk($sformatf("vec%0d_mem_din", i), din, tbl[i].din);
    end

    // Back-to-back full writes with req_valid held high.
    for (int i = 0; i < 4; i++) b2b_data[i] = $urandom;
    @(posedge clk); #1;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_wr = 1'b1; req_be = 4'hF;
    req_addr = 10'h020; req_wdata = b2b_data[0];
    idx = 0; guard = 0;
    while (idx < 4 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (req_ready) begin
        hs_cyc[idx] = cyc;
        model_step(1'b1, req_addr, req_wdata, 4'hF, elat, erd, enstb, edin);
        @(posedge clk); #1;
        idx++;
        if (idx < 4) begin
          req_addr = 10'h020 + 10'(idx); req_wdata = b2b_data[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_handshakes", 32'(idx), 32'd4);
    for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_rsp_pulses", 32'(rsp_cnt - r0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 10'h020 + 10'(i), 32'h0, 4'h0, lat, rd, nstb, din);
      chk($sformatf("b2b_readback%0d", i), rd, b2b_data[i]);
    end

    // Reset asserted during the merge cycle of an RMW.
    old = model[48];
    @(posedge clk); #1;
    s0 = strobes; r0 = rsp_cnt;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h030; req_wdata = 32'hA5A5A5A5; req_be = 4'h3;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rmw_abort_ready", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rmw_abort_no_strobe", 32'(strobes - s0), 32'd0);
    chk("rmw_abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    do_req(1'b0, 10'h030, 32'h0, 4'h0, lat, rd, nstb, din);
    chk("rmw_abort_readback", rd, old);

    // Randomised traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      a  = 10'($urandom_range(0, 19));
      d  = $urandom;
      case ($urandom_range(0, 3))
        0:       be = 4'h0;
        1:       be = 4'hF;
        default: be = 4'($urandom);
      endcase
      model_step(wr, a, d, be, elat, erd, enstb, edin);
      do_req(wr, a, d, be, lat, rd, nstb, din);
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
      chk($sformatf("rand%0d_write_strobes", i), 32'(nstb), 32'(enstb));
      if (!wr) chk($sformatf("rand%0d_rdata", i), rd, erd);
      if (enstb == 1) chk($sformatf("rand%0d_mem_din", i), din, edin);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
